ssh_led_md_reader: RTL and testbench
====================================

SSH_LED_MD_READER -- requirements
Module: ssh_led_md_reader

Interface
REQ-001 The block SHALL have parameter STABLE_CNT, default 4, giving the number of consecutive identical synchronized samples needed to qualify a sample (legal range 2..255).
REQ-002 The block SHALL have port iClk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port iRst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port iMatrix, input, 7 bits: active-low segment lines, bit0=a through bit6=g.
REQ-005 The block SHALL have port iDigitSel, input, 4 bits: active-low one-hot digit enables of a multiplexed 4-digit display.
REQ-006 The block SHALL have port iReady, input, 1 bit: the consumer accepts oBCD when iReady and oValid are both high.
REQ-007 The block SHALL have port oBCD, output, 16 bits: decoded hex digits, with digit n in bits [4n+3:4n].
REQ-008 The block SHALL have port oBlank, output, 4 bits: digit n showed all segments off.
REQ-009 The block SHALL have port oErr, output, 4 bits: digit n showed a pattern not in the decode table.
REQ-010 The block SHALL have port oValid, output, 1 bit: the presented frame is available.
REQ-011 The block SHALL have port oErrCnt, output, 8 bits: invalid-pattern count (see Configuration).

Function
REQ-012 iMatrix and iDigitSel SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A stability counter SHALL clear when the synchronized {iDigitSel,iMatrix} differs from the previous cycle's value, and SHALL increment, saturating at STABLE_CNT-1, when it is equal.
REQ-014 Exactly one qualified-sample event SHALL fire, in the cycle the counter first reaches STABLE_CNT-1.
REQ-015 A qualified sample whose iDigitSel is not exactly one bit low SHALL be discarded.
REQ-016 Decode SHALL use active-high pattern ~iMatrix: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-017 On a table match, the selected shadow digit SHALL take the nibble with blank=0 and err=0; for pattern 0000000 it SHALL take nibble 0 with blank=1; for any other pattern it SHALL keep its nibble and set err=1; in all three cases the digit's seen bit SHALL be set.
REQ-018 The FSM SHALL have states COLLECT and PRESENT.
REQ-019 In COLLECT with all 4 seen bits set, if the first-frame flag is set or the shadow {nibbles,blank,err} differs from the registered outputs, the block SHALL load the outputs and set oValid on the next edge, clear the first-frame flag, and go to PRESENT; otherwise it SHALL clear the seen bits and stay in COLLECT.
REQ-020 In PRESENT, oBCD, oBlank and oErr SHALL be held stable while qualified samples continue to update the shadow and seen bits.
REQ-021 When oValid and iReady are both high, the block SHALL clear oValid and all seen bits and go to COLLECT on that edge; a qualified sample in the same cycle SHALL be written to the shadow, but its seen bit SHALL be cleared, because clearing wins.
REQ-022 iReady while oValid is low SHALL have no effect.
REQ-023 Latency from a pin change to a qualified sample SHALL be 2 + STABLE_CNT cycles.

Reset
REQ-024 While iRst_n is low, the outputs SHALL be oBCD=0, oBlank=0, oErr=0, oValid=0 and oErrCnt=0; the state SHALL be COLLECT, the seen bits 0 and the shadow 0, and the first-frame flag SHALL be set.
REQ-025 Reset SHALL load the synchronizers and the previous-sample register with all ones (idle bus) and clear the stability counter.
REQ-026 Reset asserted in PRESENT SHALL drop oValid immediately (asynchronous), and the frame SHALL NOT be re-presented.

Configuration
REQ-027 The macro SSH_LED_MD_READER_ERRCNT_EN SHALL control the error counter.
REQ-028 With SSH_LED_MD_READER_ERRCNT_EN defined, oErrCnt SHALL increment by one on each qualified sample with an invalid pattern and saturate at 255.
REQ-029 Without SSH_LED_MD_READER_ERRCNT_EN, oErrCnt SHALL be constant 0 and the block SHALL contain no counter logic.

Verification
REQ-030 Drive digits 0..3 as 1,2,3,4 (iMatrix=~0000110 etc.), each held 8 cycles, with iReady=1 -> oBCD=16'h4321, oBlank=0, oErr=0, one oValid pulse.
REQ-031 Repeat the same scan continuously -> no further oValid; then change digit 2 to 7 -> oBCD=16'h4721 presented once.
REQ-032 Digit 1 with iMatrix=7'b1111111, digit 3 with ~0101010 (invalid), ERRCNT_EN defined -> oBlank=4'b0010, oErr=4'b1000, oErrCnt=1; the same scan without the macro -> oErrCnt=0.
REQ-033 Hold each digit only STABLE_CNT+1 cycles, toggling iMatrix every 2 cycles -> no qualified samples, oValid stays 0; iDigitSel=4'b1100 held 10 cycles -> discarded.
REQ-034 Frame presented with iReady=0 for 50 cycles while the display changes -> oBCD stable; then iReady=1 -> handshake completes, next frame shows new value; assert iRst_n=0 mid-PRESENT -> oValid=0 same cycle, all outputs 0.

Source files
------------

// File: rtl/ssh_led_md_reader.sv
// Reads a multiplexed 4-digit, active-low 7-segment display and presents decoded hex frames.
// Build option: define SSH_LED_MD_READER_ERRCNT_EN to enable the saturating invalid-pattern counter.
module ssh_led_md_reader #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [6:0]  iMatrix,
    input  logic [3:0]  iDigitSel,
    input  logic        iReady,
    output logic [15:0] oBCD,
    output logic [3:0]  oBlank,
    output logic [3:0]  oErr,
    output logic        oValid,
    output logic [7:0]  oErrCnt
);

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_PRESENT = 1'b1;

    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CNT - 1);
    localparam logic [7:0] CNT_QUAL = 8'(STABLE_CNT - 2);

    logic [10:0] sync1_q, sync2_q, prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        qual;

    logic [3:0]  sel_act;
    logic [6:0]  seg;
    logic        sel_ok;
    logic [1:0]  sel_idx;
    logic        dec_hit;
    logic [3:0]  dec_nib;

    logic [15:0] shd_nib_q, shd_nib_d;
    logic [3:0]  shd_blank_q, shd_blank_d;
    logic [3:0]  shd_err_q, shd_err_d;
    logic [3:0]  seen_q, seen_d;
    logic [0:0]  state_q, state_d;
    logic        first_q, first_d;
    logic [15:0] bcd_q, bcd_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  err_q, err_d;
    logic        frame_diff;

    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0111111: r = {1'b1, 4'h0};
            7'b0000110: r = {1'b1, 4'h1};
            7'b1011011: r = {1'b1, 4'h2};
            7'b1001111: r = {1'b1, 4'h3};
            7'b1100110: r = {1'b1, 4'h4};
            7'b1101101: r = {1'b1, 4'h5};
            7'b1111101: r = {1'b1, 4'h6};
            7'b0000111: r = {1'b1, 4'h7};
            7'b1111111: r = {1'b1, 4'h8};
            7'b1100111: r = {1'b1, 4'h9};
            7'b1110111: r = {1'b1, 4'hA};
            7'b1111100: r = {1'b1, 4'hB};
            7'b0111001: r = {1'b1, 4'hC};
            7'b1011110: r = {1'b1, 4'hD};
            7'b1111001: r = {1'b1, 4'hE};
            7'b1110001: r = {1'b1, 4'hF};
            default:    r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    // Synchronizers and previous sample idle at all ones, matching an undriven active-low bus.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {iDigitSel, iMatrix};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        if (sync2_q != prev_q)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 8'd1;
        else
            cnt_d = cnt_q;
    end

    // Fires once per stable run, on the edge the counter reaches STABLE_CNT-1.
    assign qual    = (sync2_q == prev_q) && (cnt_q == CNT_QUAL);
    assign sel_act = ~sync2_q[10:7];
    assign seg     = ~sync2_q[6:0];
    assign {dec_hit, dec_nib} = decode_seg(seg);

    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (sel_act)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    assign frame_diff = {shd_nib_q, shd_blank_q, shd_err_q} != {bcd_q, blank_q, err_q};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        shd_nib_d   = shd_nib_q;
        shd_blank_d = shd_blank_q;
        shd_err_d   = shd_err_q;
        seen_d      = seen_q;
        state_d     = state_q;
        first_d     = first_q;
        bcd_d       = bcd_q;
        blank_d     = blank_q;
        err_d       = err_q;

        if (qual && sel_ok) begin
            seen_d[sel_idx] = 1'b1;
            if (dec_hit) begin
                shd_nib_d[{sel_idx, 2'b00} +: 4] = dec_nib;
                shd_blank_d[sel_idx]             = 1'b0;
                shd_err_d[sel_idx]               = 1'b0;
            end else if (seg == 7'd0) begin
                shd_nib_d[{sel_idx, 2'b00} +: 4] = 4'h0;
                shd_blank_d[sel_idx]             = 1'b1;
                shd_err_d[sel_idx]               = 1'b0;
            end else begin
                shd_blank_d[sel_idx] = 1'b0;
                shd_err_d[sel_idx]   = 1'b1;
            end
        end

        // Seen-bit clears below override any bit set by a same-cycle sample.
        case (state_q)
            S_COLLECT: begin
                if (&seen_q) begin
                    if (first_q || frame_diff) begin
                        bcd_d   = shd_nib_q;
                        blank_d = shd_blank_q;
                        err_d   = shd_err_q;
                        first_d = 1'b0;
                        state_d = S_PRESENT;
                    end else begin
                        seen_d = '0;
                    end
                end
            end
            S_PRESENT: begin
                if (iReady) begin
                    seen_d  = '0;
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            shd_nib_q   <= '0;
            shd_blank_q <= '0;
            shd_err_q   <= '0;
            seen_q      <= '0;
            state_q     <= S_COLLECT;
            first_q     <= 1'b1;
            bcd_q       <= '0;
            blank_q     <= '0;
            err_q       <= '0;
        end else begin
            shd_nib_q   <= shd_nib_d;
            shd_blank_q <= shd_blank_d;
            shd_err_q   <= shd_err_d;
            seen_q      <= seen_d;
            state_q     <= state_d;
            first_q     <= first_d;
            bcd_q       <= bcd_d;
            blank_q     <= blank_d;
            err_q       <= err_d;
        end
    end

    assign oBCD   = bcd_q;
    assign oBlank = blank_q;
    assign oErr   = err_q;
    assign oValid = (state_q == S_PRESENT);

`ifdef SSH_LED_MD_READER_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;
    logic       bad_sample;

    assign bad_sample = qual && sel_ok && !dec_hit && (seg != 7'd0);
    assign errcnt_d   = (bad_sample && (errcnt_q != 8'hFF)) ? errcnt_q + 8'd1 : errcnt_q;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)
            errcnt_q <= '0;
        else
            errcnt_q <= errcnt_d;
    end

    assign oErrCnt = errcnt_q;
`else
    assign oErrCnt = '0;
`endif

endmodule

// File: tb/tb_ssh_led_md_reader.sv
// Self-checking bench for ssh_led_md_reader: directed display scans plus random scans,
// compared every cycle against a run-length / table-lookup reference model.
module tb_ssh_led_md_reader;

    localparam int unsigned STABLE_CNT = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1100111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    logic        iClk;
    logic        iRst_n;
    logic [6:0]  iMatrix;
    logic [3:0]  iDigitSel;
    logic        iReady;
    logic [15:0] oBCD;
    logic [3:0]  oBlank;
    logic [3:0]  oErr;
    logic        oValid;
    logic [7:0]  oErrCnt;

    ssh_led_md_reader #(.STABLE_CNT(STABLE_CNT)) dut (
        .iClk      (iClk),
        .iRst_n    (iRst_n),
        .iMatrix   (iMatrix),
        .iDigitSel (iDigitSel),
        .iReady    (iReady),
        .oBCD      (oBCD),
        .oBlank    (oBlank),
        .oErr      (oErr),
        .oValid    (oValid),
        .oErrCnt   (oErrCnt)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int tb_decode(input logic [6:0] p);
        for (int k = 0; k < 16; k++)
            if (SEG_TAB[k] == p) return k;
        return -1;
    endfunction

    // Reference model: pin history, run length of the synchronized value, per-digit shadow.
    logic [10:0] m_pin1, m_pin2;
    int          m_run;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_sblank, m_serr, m_seen;
    logic        m_present, m_first;
    logic [15:0] m_bcd;
    logic [3:0]  m_blank, m_err;
    int          m_errcnt;

    logic [15:0] t_snap_bcd;
    logic [3:0]  t_snap_blank, t_snap_err, t_new_seen, t_sel, t_one;
    logic [6:0]  t_seg;
    int          t_digit, t_code;

    task automatic model_reset();
        m_pin1 = '1; m_pin2 = '1;
        m_run = 2;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_sblank = '0; m_serr = '0; m_seen = '0;
        m_present = 1'b0; m_first = 1'b1;
        m_bcd = '0; m_blank = '0; m_err = '0;
        m_errcnt = 0;
    endtask

    task automatic model_step();
        t_snap_bcd   = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        t_snap_blank = m_sblank;
        t_snap_err   = m_serr;
        t_new_seen   = m_seen;
        t_sel        = m_pin2[10:7];
        t_seg        = ~m_pin2[6:0];
        t_digit      = -1;
        for (int i = 0; i < 4; i++) begin
            t_one = 4'b0001 << i;
            if (t_sel == ~t_one) t_digit = i;
        end
        if (m_run == int'(STABLE_CNT) && t_digit >= 0) begin
            t_new_seen[t_digit] = 1'b1;
            t_code = tb_decode(t_seg);
            if (t_code >= 0) begin
                m_nib[t_digit] = 4'(t_code);
                m_sblank[t_digit] = 1'b0;
                m_serr[t_digit] = 1'b0;
            end else if (t_seg == 7'd0) begin
                m_nib[t_digit] = 4'h0;
                m_sblank[t_digit] = 1'b1;
                m_serr[t_digit] = 1'b0;
            end else begin
                m_sblank[t_digit] = 1'b0;
                m_serr[t_digit] = 1'b1;
`ifdef SSH_LED_MD_READER_ERRCNT_EN
                if (m_errcnt < 255) m_errcnt++;
`endif
            end
        end
        if (!m_present) begin
            if (m_seen == 4'hF) begin
                if (m_first || {t_snap_bcd, t_snap_blank, t_snap_err} != {m_bcd, m_blank, m_err}) begin
                    m_bcd = t_snap_bcd; m_blank = t_snap_blank; m_err = t_snap_err;
                    m_present = 1'b1; m_first = 1'b0;
                end else begin
                    t_new_seen = '0;
                end
            end
        end else if (iReady) begin
            m_present = 1'b0;
            t_new_seen = '0;
        end
        m_seen = t_new_seen;
        if (m_pin1 == m_pin2) begin
            if (m_run < 1000) m_run++;
        end else begin
            m_run = 1;
        end
        m_pin2 = m_pin1;
        m_pin1 = {iDigitSel, iMatrix};
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge iClk or negedge iRst_n);
            if (!iRst_n) model_reset();
            else model_step();
        end
    end

    int   pulses = 0;
    logic valid_prev = 1'b0;

    initial begin
        forever begin
            @(negedge iClk);
            check("bcd", 32'(oBCD), 32'(m_bcd));
            check("blank", 32'(oBlank), 32'(m_blank));
            check("err", 32'(oErr), 32'(m_err));
            check("valid", 32'(oValid), 32'(m_present));
            check("errcnt", 32'(oErrCnt), 32'(m_errcnt));
            if (oValid && !valid_prev) pulses++;
            valid_prev = oValid;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic show_raw(input logic [3:0] sel_n, input logic [6:0] pat, input int hold);
        iDigitSel = sel_n;
        iMatrix   = ~pat;
        repeat (hold) @(posedge iClk);
        #1;
    endtask

    task automatic show(input int digit, input logic [6:0] pat, input int hold);
        logic [3:0] one;
        one = 4'b0001 << digit;
        show_raw(~one, pat, hold);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3, input int hold);
        show(0, p0, hold);
        show(1, p1, hold);
        show(2, p2, hold);
        show(3, p3, hold);
    endtask

    int         p_base;
    logic [6:0] rpat;
    int         r;

    initial begin
        iRst_n = 1'b0; iMatrix = '1; iDigitSel = '1; iReady = 1'b0;
        repeat (3) @(posedge iClk);
        #1;
        check("rst_bcd", 32'(oBCD), 32'h0);
        check("rst_valid", 32'(oValid), 32'h0);
        check("rst_errcnt", 32'(oErrCnt), 32'h0);
        iRst_n = 1'b1;
        repeat (5) @(posedge iClk);
        #1;

        // First frame 1,2,3,4 with consumer always ready.
        iReady = 1'b1;
        scan(SEG_TAB[1], SEG_TAB[2], SEG_TAB[3], SEG_TAB[4], 8);
        repeat (4) @(posedge iClk);
        #1;
        check("f1_bcd", 32'(oBCD), 32'h4321);
        check("f1_blank", 32'(oBlank), 32'h0);
        check("f1_err", 32'(oErr), 32'h0);
        check("f1_pulses", 32'(pulses), 32'd1);

        // Unchanged scans must not present again; then digit 2 changes to 7.
        repeat (3) scan(SEG_TAB[1], SEG_TAB[2], SEG_TAB[3], SEG_TAB[4], 8);
        check("repeat_pulses", 32'(pulses), 32'd1);
        repeat (2) scan(SEG_TAB[1], SEG_TAB[2], SEG_TAB[7], SEG_TAB[4], 8);
        check("f2_bcd", 32'(oBCD), 32'h4721);
        check("f2_pulses", 32'(pulses), 32'd2);

        // Blank digit 1 and invalid digit 3 (nibble of digit 3 is kept).
        scan(SEG_TAB[1], 7'b0000000, SEG_TAB[3], 7'b0101010, 8);
        repeat (4) @(posedge iClk);
        #1;
        check("f3_bcd", 32'(oBCD), 32'h4301);
        check("f3_blank", 32'(oBlank), 32'b0010);
        check("f3_err", 32'(oErr), 32'b1000);
`ifdef SSH_LED_MD_READER_ERRCNT_EN
        check("f3_errcnt", 32'(oErrCnt), 32'd1);
`else
        check("f3_errcnt", 32'(oErrCnt), 32'd0);
`endif
        check("f3_pulses", 32'(pulses), 32'd3);

        // Too-short holds with toggling segments, then a two-hot select: nothing qualifies.
        p_base = pulses;
        for (int d = 0; d < 4; d++) begin
            show(d, SEG_TAB[5], 2);
            show(d, SEG_TAB[6], 2);
            show(d, SEG_TAB[5], 1);
        end
        show_raw(4'b1100, SEG_TAB[9], 10);
        repeat (8) @(posedge iClk);
        #1;
        check("short_valid", 32'(oValid), 32'h0);
        check("short_pulses", 32'(pulses), 32'(p_base));
        check("short_bcd", 32'(oBCD), 32'h4301);

        // Back-pressure: the frame holds while the display keeps changing.
        iReady = 1'b0;
        scan(SEG_TAB[5], SEG_TAB[6], SEG_TAB[7], SEG_TAB[8], 8);
        check("bp_valid", 32'(oValid), 32'h1);
        check("bp_bcd", 32'(oBCD), 32'h8765);
        repeat (2) scan(SEG_TAB[9], SEG_TAB[10], SEG_TAB[11], SEG_TAB[12], 8);
        check("bp_hold_bcd", 32'(oBCD), 32'h8765);
        check("bp_hold_valid", 32'(oValid), 32'h1);
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        check("bp_ack_valid", 32'(oValid), 32'h0);
        p_base = pulses;
        scan(SEG_TAB[9], SEG_TAB[10], SEG_TAB[11], SEG_TAB[12], 8);
        repeat (3) @(posedge iClk);
        #1;
        check("bp_next_bcd", 32'(oBCD), 32'hCBA9);
        check("bp_next_pulses", 32'(pulses), 32'(p_base + 1));

        // Reset in PRESENT drops everything asynchronously; no re-presentation afterwards.
        iReady = 1'b0;
        scan(SEG_TAB[1], SEG_TAB[1], SEG_TAB[1], SEG_TAB[1], 8);
        check("pre_rst_valid", 32'(oValid), 32'h1);
        @(posedge iClk);
        #2;
        iRst_n = 1'b0;
        #1;
        check("arst_valid", 32'(oValid), 32'h0);
        check("arst_bcd", 32'(oBCD), 32'h0);
        check("arst_blank", 32'(oBlank), 32'h0);
        check("arst_err", 32'(oErr), 32'h0);
        check("arst_errcnt", 32'(oErrCnt), 32'h0);
        repeat (2) @(posedge iClk);
        #1;
        iRst_n = 1'b1;
        p_base = pulses;
        repeat (20) @(posedge iClk);
        #1;
        check("post_rst_valid", 32'(oValid), 32'h0);
        check("post_rst_pulses", 32'(pulses), 32'(p_base));

        // Random scans, judged by the per-cycle model comparison.
        for (int n = 0; n < 400; n++) begin
            iReady = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r < 8) begin
                rpat = SEG_TAB[$urandom_range(0, 15)];
            end else if (r == 8) begin
                rpat = 7'd0;
            end else begin
                rpat = 7'($urandom);
                if (tb_decode(rpat) >= 0 || rpat == 7'd0) rpat = 7'b0101010;
            end
            if ($urandom_range(0, 19) == 0)
                show_raw(4'($urandom), rpat, int'($urandom_range(1, 9)));
            else
                show(int'($urandom_range(0, 3)), rpat, int'($urandom_range(1, 9)));
        end
        iReady = 1'b1;
        repeat (10) @(posedge iClk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
